sugar_setup_ctrl: RTL and testbench

- Setup-phase sequencer for the sugar subsystem. Places up to NUM_PATCHES sugar_patch instances at collision-free random locations, then sweeps the grid once to write sugar into the map memory.
- Sits between the LFSR/random source, the bank of sugar_patch instances (their SET, SETUP_PHASE, collide_x/y and writeLoc_x/y inputs) and the map-memory write port.
- Releases the simulation by asserting done.

---
 rtl/sugar_setup_ctrl.sv | 166 ++++++++++++++++
 tb/tb_sugar_setup_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sugar_setup_ctrl.sv
// rtl/sugar_setup_ctrl.sv - setup sequencer: random sugar patch placement, then one map-write sweep
module sugar_setup_ctrl #(
    parameter int X_bits      = 8,
    parameter int Y_bits      = 7,
    parameter int GRID_W      = 160,
    parameter int GRID_H      = 120,
    parameter int NUM_PATCHES = 4,
    parameter int MAX_TRIES   = 15
) (
    input  logic                               setup_clk,
    input  logic                               RESET,
    input  logic                               start,
    input  logic [X_bits-1:0]                  rand_x,
    input  logic [Y_bits-1:0]                  rand_y,
    input  logic                               collision_any,
    input  logic                               placeSugar_any,
    output logic                               SETUP_PHASE,
    output logic [X_bits-1:0]                  cand_x,
    output logic [Y_bits-1:0]                  cand_y,
    output logic [NUM_PATCHES-1:0]             patch_set,
    output logic [NUM_PATCHES-1:0]             patch_valid,
    output logic [X_bits-1:0]                  writeLoc_x,
    output logic [Y_bits-1:0]                  writeLoc_y,
    output logic                               SETUP_SUGARPLACE,
    output logic                               sugar_we,
    output logic [$clog2(NUM_PATCHES+1)-1:0]   placed_cnt,
    output logic                               done
);

    localparam int IDX_W = (NUM_PATCHES > 1) ? $clog2(NUM_PATCHES) : 1;
    localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam int CNT_W = $clog2(NUM_PATCHES + 1);

    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_PATCHES - 1);
    localparam logic [TRY_W-1:0]  TRY_LAST   = TRY_W'(MAX_TRIES - 1);
    localparam logic [X_bits-1:0] X_LAST     = X_bits'(GRID_W - 1);
    localparam logic [Y_bits-1:0] Y_LAST     = Y_bits'(GRID_H - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PROPOSE,
        S_CHECK,
        S_COMMIT,
        S_SCAN,
        S_DONE
    } state_t;

    state_t            state, state_next;
    logic [IDX_W-1:0]  idx;
    logic [TRY_W-1:0]  tries;

    logic idx_last, tries_last, x_last, y_last, enter_scan;

    assign idx_last   = (idx == IDX_LAST);
    assign tries_last = (tries == TRY_LAST);
    assign x_last     = (writeLoc_x == X_LAST);
    assign y_last     = (writeLoc_y == Y_LAST);
    assign enter_scan = (state_next == S_SCAN) && (state != S_SCAN);

    always_ff @(posedge setup_clk or posedge RESET) begin
        if (RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next       = state;
        patch_set        = '0;
        SETUP_PHASE      = 1'b1;
        SETUP_SUGARPLACE = 1'b0;
        sugar_we         = 1'b0;
        done             = 1'b0;
        case (state)
            S_IDLE: begin
                SETUP_PHASE = 1'b0;
                if (start) state_next = S_PROPOSE;
            end
            S_PROPOSE: state_next = S_CHECK;
            S_CHECK: begin
                if (!collision_any)  state_next = S_COMMIT;
                else if (!tries_last) state_next = S_PROPOSE;
                else if (idx_last)    state_next = S_SCAN;
                else                  state_next = S_PROPOSE;
            end
            S_COMMIT: begin
                patch_set[idx] = 1'b1;
                state_next     = idx_last ? S_SCAN : S_PROPOSE;
            end
            S_SCAN: begin
                SETUP_SUGARPLACE = 1'b1;
                sugar_we         = placeSugar_any;
                if (x_last && y_last) state_next = S_DONE;
            end
            S_DONE: begin
                SETUP_PHASE = 1'b0;
                done        = 1'b1;
                if (start) state_next = S_PROPOSE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge setup_clk or posedge RESET) begin
        if (RESET) begin
            patch_valid <= '0;
            placed_cnt  <= '0;
            cand_x      <= '0;
            cand_y      <= '0;
            writeLoc_x  <= '0;
            writeLoc_y  <= '0;
            tries       <= '0;
            idx         <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        patch_valid <= '0;
                        placed_cnt  <= '0;
                        tries       <= '0;
                        idx         <= '0;
                    end
                end
                S_PROPOSE: begin
                    cand_x <= rand_x;
                    cand_y <= rand_y;
                end
                S_CHECK: begin
                    if (collision_any) begin
                        if (!tries_last) begin
                            tries <= tries + TRY_W'(1);
                        end else begin
                            // Out of attempts: this patch stays invalid and is never revisited
                            tries <= '0;
                            idx   <= idx + IDX_W'(1);
                        end
                    end
                end
                S_COMMIT: begin
                    patch_valid[idx] <= 1'b1;
                    placed_cnt       <= placed_cnt + CNT_W'(1);
                    idx              <= idx + IDX_W'(1);
                    tries            <= '0;
                end
                S_SCAN: begin
                    // Final cell holds its coordinates so DONE shows the last write location
                    if (x_last) begin
                        if (!y_last) begin
                            writeLoc_x <= '0;
                            writeLoc_y <= writeLoc_y + Y_bits'(1);
                        end
                    end else begin
                        writeLoc_x <= writeLoc_x + X_bits'(1);
                    end
                end
                default: ;
            endcase
            if (enter_scan) begin
                writeLoc_x <= '0;
                writeLoc_y <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sugar_setup_ctrl.sv
// tb/tb_sugar_setup_ctrl.sv - directed self-checking bench for sugar_setup_ctrl
module tb_sugar_setup_ctrl;

    localparam int GW = 160;
    localparam int GH = 120;
    localparam int MT = 15;

    logic       setup_clk;
    logic       RESET;
    logic       start;
    logic [7:0] rand_x;
    logic [6:0] rand_y;
    logic       collision_any;
    logic       placeSugar_any;
    logic       SETUP_PHASE;
    logic [7:0] cand_x;
    logic [6:0] cand_y;
    logic [3:0] patch_set;
    logic [3:0] patch_valid;
    logic [7:0] writeLoc_x;
    logic [6:0] writeLoc_y;
    logic       SETUP_SUGARPLACE;
    logic       sugar_we;
    logic [2:0] placed_cnt;
    logic       done;

    sugar_setup_ctrl dut (
        .setup_clk        (setup_clk),
        .RESET            (RESET),
        .start            (start),
        .rand_x           (rand_x),
        .rand_y           (rand_y),
        .collision_any    (collision_any),
        .placeSugar_any   (placeSugar_any),
        .SETUP_PHASE      (SETUP_PHASE),
        .cand_x           (cand_x),
        .cand_y           (cand_y),
        .patch_set        (patch_set),
        .patch_valid      (patch_valid),
        .writeLoc_x       (writeLoc_x),
        .writeLoc_y       (writeLoc_y),
        .SETUP_SUGARPLACE (SETUP_SUGARPLACE),
        .sugar_we         (sugar_we),
        .placed_cnt       (placed_cnt),
        .done             (done)
    );

    initial setup_clk = 1'b0;
    always #5 setup_clk = ~setup_clk;

    // Stand-in for the patch bank: sugar lives in the 5x5 block x,y in 8..12
    logic sugar_en;
    assign placeSugar_any = sugar_en && (writeLoc_x >= 8'd8) && (writeLoc_x <= 8'd12)
                            && (writeLoc_y >= 7'd8) && (writeLoc_y <= 7'd12);

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge setup_clk);
    endtask

    int         tx[4] = '{10, 50, 90, 130};
    int         ty[4] = '{10, 20, 60, 100};
    int         ncoll[4];
    int         commit_cyc[4];
    logic [3:0] exp_valid;
    int         exp_cnt;

    task automatic do_start(input bit from_done);
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        check_val("start_done_drop", done, 0);
        if (from_done) begin
            check_val("restart_valid_clr", patch_valid, 0);
            check_val("restart_cnt_clr", placed_cnt, 0);
        end
    endtask

    // Walks the expected PROPOSE/CHECK/COMMIT schedule; cycle 1 is the first after start
    task automatic place(input bit start_in_check);
        int         cyc;
        logic [7:0] rx;
        logic [6:0] ry;
        cyc       = 1;
        exp_valid = '0;
        exp_cnt   = 0;
        for (int p = 0; p < 4; p++) begin
            commit_cyc[p] = -1;
            for (int k = 0; k < MT; k++) begin
                rx = 8'(tx[p] + 2 * k);
                ry = 7'(ty[p] + k);
                rand_x = rx;
                rand_y = ry;
                #1;
                check_val("prop_set", patch_set, 0);
                check_val("prop_phase", SETUP_PHASE, 1);
                tick(); cyc++;
                rand_x = 8'd0;
                rand_y = 7'd0;
                collision_any = (k < ncoll[p]);
                if (start_in_check && p == 0 && k == 0) start = 1'b1;
                #1;
                check_val("chk_cand", {cand_x, cand_y}, {rx, ry});
                check_val("chk_set", patch_set, 0);
                check_val("chk_valid", patch_valid, exp_valid);
                tick(); cyc++;
                collision_any = 1'b0;
                start = 1'b0;
                if (k >= ncoll[p]) begin
                    #1;
                    check_val("commit_set", patch_set, 4'b0001 << p);
                    check_val("commit_cand", {cand_x, cand_y}, {rx, ry});
                    commit_cyc[p] = cyc;
                    tick(); cyc++;
                    exp_valid[p] = 1'b1;
                    exp_cnt++;
                    break;
                end
            end
        end
        #1;
        check_val("place_valid", patch_valid, exp_valid);
        check_val("place_cnt", placed_cnt, exp_cnt);
        check_val("scan_entry_sp", SETUP_SUGARPLACE, 1);
    endtask

    // Returns early at the start of scan cycle stop_at when stop_at >= 0
    task automatic scan(input bit sugar_on, input int stop_at);
        int bad;
        int we_cnt;
        int ex, ey;
        bit insq;
        sugar_en = sugar_on;
        bad      = 0;
        we_cnt   = 0;
        for (int i = 0; i < GW * GH; i++) begin
            if (i == stop_at) return;
            #1;
            ex   = i % GW;
            ey   = i / GW;
            insq = sugar_on && ex >= 8 && ex <= 12 && ey >= 8 && ey <= 12;
            if (writeLoc_x !== 8'(ex) || writeLoc_y !== 7'(ey) || SETUP_SUGARPLACE !== 1'b1
                || sugar_we !== insq || done !== 1'b0 || patch_set !== 4'b0 || SETUP_PHASE !== 1'b1)
                bad++;
            if (sugar_we === 1'b1) we_cnt++;
            tick();
        end
        check_val("scan_bad_cycles", bad, 0);
        check_val("scan_we_count", we_cnt, sugar_on ? 25 : 0);
        #1;
        check_val("done_high", done, 1);
        check_val("done_phase", SETUP_PHASE, 0);
        check_val("done_sp", SETUP_SUGARPLACE, 0);
        check_val("done_we", sugar_we, 0);
        check_val("done_wl", {writeLoc_x, writeLoc_y}, {8'd159, 7'd119});
        tick();
        #1;
        check_val("done_hold", done, 1);
        check_val("done_hold_valid", patch_valid, exp_valid);
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_set"}, patch_set, 0);
        check_val({tag, "_valid"}, patch_valid, 0);
        check_val({tag, "_cnt"}, placed_cnt, 0);
        check_val({tag, "_cand"}, {cand_x, cand_y}, 0);
        check_val({tag, "_wl"}, {writeLoc_x, writeLoc_y}, 0);
        check_val({tag, "_flags"}, {done, SETUP_PHASE, SETUP_SUGARPLACE, sugar_we}, 0);
    endtask

    initial begin
        RESET         = 1'b1;
        start         = 1'b0;
        rand_x        = '0;
        rand_y        = '0;
        collision_any = 1'b0;
        sugar_en      = 1'b0;
        #1;
        check_reset_vals("rst");
        tick(); tick();
        RESET = 1'b0;
        tick();
        #1;
        check_val("idle_phase", SETUP_PHASE, 0);
        check_val("idle_done", done, 0);

        // No collisions, start pulse during first CHECK must be ignored
        ncoll = '{0, 0, 0, 0};
        do_start(1'b0);
        place(1'b1);
        check_val("t1_cyc0", commit_cyc[0], 3);
        check_val("t1_cyc1", commit_cyc[1], 6);
        check_val("t1_cyc2", commit_cyc[2], 9);
        check_val("t1_cyc3", commit_cyc[3], 12);
        check_val("t1_valid", patch_valid, 4'b1111);
        scan(1'b1, -1);

        // Patch 0 placed on third attempt; patch 1 survives 14 collisions
        ncoll = '{2, 14, 0, 0};
        do_start(1'b1);
        place(1'b0);
        check_val("t2_cyc0", commit_cyc[0], 7);
        check_val("t2_cyc1", commit_cyc[1], 38);
        check_val("t2_cnt", placed_cnt, 4);
        scan(1'b0, -1);

        // Patch 1 exhausts all attempts and is skipped
        ncoll = '{0, MT, 0, 0};
        do_start(1'b1);
        place(1'b0);
        check_val("t3_cyc1", commit_cyc[1], -1);
        check_val("t3_cyc2", commit_cyc[2], 36);
        check_val("t3_valid", patch_valid, 4'b1101);
        check_val("t3_cnt", placed_cnt, 3);
        scan(1'b1, -1);

        // Asynchronous reset mid-scan at (37,5)
        ncoll = '{0, 0, 0, 0};
        do_start(1'b1);
        place(1'b0);
        scan(1'b1, 5 * GW + 37);
        #1;
        check_val("mid_wl", {writeLoc_x, writeLoc_y}, {8'd37, 7'd5});
        RESET = 1'b1;
        #1;
        check_reset_vals("async");
        tick();
        RESET = 1'b0;
        tick();
        ncoll = '{0, 0, 0, 0};
        do_start(1'b0);
        place(1'b0);
        check_val("rerun_cyc0", commit_cyc[0], 3);
        check_val("rerun_valid", patch_valid, 4'b1111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
